// File: rtl/dll_initfc_ctrl_if.sv
// ---------------------------------------------------------------------------
// dll_initfc_ctrl_if
// Purpose : DLLP transmit-request channel between the flow-control init
//           sequencer and the DLLP generator (valid/ready handshake).
// Signals :
//   tx_req_valid  sequencer -> generator  request valid
//   tx_req_ready  generator -> sequencer  request accepted this cycle
//   tx_dllp_type  sequencer -> generator  DLLP type byte
//   tx_hdr_fc     sequencer -> generator  header credit field (8 bits)
//   tx_data_fc    sequencer -> generator  data credit field (12 bits)
// Modports: master = sequencer side, slave = generator side.
// ---------------------------------------------------------------------------
interface dll_initfc_ctrl_if;
    logic        tx_req_valid;
    logic        tx_req_ready;
    logic [7:0]  tx_dllp_type;
    logic [7:0]  tx_hdr_fc;
    logic [11:0] tx_data_fc;

    modport master (
        output tx_req_valid,
        output tx_dllp_type,
        output tx_hdr_fc,
        output tx_data_fc,
        input  tx_req_ready
    );

    modport slave (
        input  tx_req_valid,
        input  tx_dllp_type,
        input  tx_hdr_fc,
        input  tx_data_fc,
        output tx_req_ready
    );
endinterface

// File: rtl/dll_initfc_ctrl.sv
// ---------------------------------------------------------------------------
// dll_initfc_ctrl
// Purpose : Sequences the VC0 flow-control init handshake (FC_INIT1 then
//           FC_INIT2). Repeatedly schedules InitFC1/InitFC2 triplets
//           (P, NP, Cpl) toward the DLLP generator, tracks received
//           InitFC/UpdateFC DLLPs and reports init1/init2 completion to the
//           DLCM state machine.
// Optional: define DLL_INITFC_TIMEOUT_EN to add a watchdog that restarts the
//           sequence at FI1_SEND after TIMEOUT_CYCLES cycles spent outside
//           IDLE/DONE. Without it, timeout_o is tied low.
// Ports   :
//   sclk             clock
//   srst             reset, asynchronous, active-high
//   dl_init_i        1 = DLCM in INIT1/INIT2; 0 aborts to IDLE
//   rx_dllp_valid_i  decoded DLLP strobe
//   rx_dllp_type_i   decoded DLLP type byte
//   tx_if            transmit-request channel (master modport)
//   init1_end_o      FC_INIT1 complete (level)
//   init2_end_o      FC_INIT2 complete (level)
//   fc_state_o       state encoding (IDLE=0 .. DONE=5)
//   timeout_o        watchdog fired (1-cycle pulse)
// ---------------------------------------------------------------------------
module dll_initfc_ctrl #(
    parameter logic [7:0]  PH_CREDIT     = 8'd32,
    parameter logic [11:0] PD_CREDIT     = 12'd256,
    parameter logic [7:0]  NPH_CREDIT    = 8'd32,
    parameter logic [11:0] NPD_CREDIT    = 12'd64,
    parameter logic [7:0]  CPLH_CREDIT   = 8'd0,
    parameter logic [11:0] CPLD_CREDIT   = 12'd0,
    parameter int unsigned RESEND_CYCLES = 1024
`ifdef DLL_INITFC_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65536
`endif
) (
    input  logic                     sclk,
    input  logic                     srst,
    input  logic                     dl_init_i,
    input  logic                     rx_dllp_valid_i,
    input  logic [7:0]               rx_dllp_type_i,
    dll_initfc_ctrl_if.master        tx_if,
    output logic                     init1_end_o,
    output logic                     init2_end_o,
    output logic [2:0]               fc_state_o,
    output logic                     timeout_o
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FI1_SEND = 3'd1,
        ST_FI1_WAIT = 3'd2,
        ST_FI2_SEND = 3'd3,
        ST_FI2_WAIT = 3'd4,
        ST_DONE     = 3'd5
    } fc_state_t;

    localparam int CNT_W = (RESEND_CYCLES > 2) ? $clog2(RESEND_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RESEND_CYCLES - 1);

    localparam logic [1:0] IDX_P   = 2'd0;
    localparam logic [1:0] IDX_CPL = 2'd2;

    fc_state_t        state_reg, state_next;
    logic [1:0]       idx_reg, idx_next;
    logic [CNT_W-1:0] wait_reg, wait_next;
    logic             sent_reg, sent_next;
    logic [2:0]       fi1_reg;
    logic [2:0]       fi1_hit;
    logic             fi2_reg;
    logic             fi2_hit;
    logic             clr_fi1;
    logic             clr_fi2;
    logic             tx_valid;
    logic             in_fi1;
    logic             phase_ok;
    logic             wd_fire;

    // -----------------------------------------------------------------------
    // Receive tracking. Strobes are ignored while dl_init_i is low so that an
    // abort always leaves the flags cleared. A strobe on the same cycle as a
    // clear is kept (set wins) so nothing received on a state-entry edge is
    // lost.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_fi1
        localparam logic [7:0] FI1_TYPE = 8'h40 + 8'(gi * 16);

        assign fi1_hit[gi] = rx_dllp_valid_i && dl_init_i && (rx_dllp_type_i == FI1_TYPE);

        always_ff @(posedge sclk or posedge srst) begin
            if (srst) begin
                fi1_reg[gi] <= 1'b0;
            end else begin
                fi1_reg[gi] <= (fi1_reg[gi] & ~clr_fi1) | fi1_hit[gi];
            end
        end
    end

    // InitFC2 of any class, or an UpdateFC, proves the peer reached FC_INIT2.
    assign fi2_hit = rx_dllp_valid_i && dl_init_i &&
                     ((rx_dllp_type_i == 8'hC0) || (rx_dllp_type_i == 8'hD0) ||
                      (rx_dllp_type_i == 8'hE0) || (rx_dllp_type_i == 8'h80) ||
                      (rx_dllp_type_i == 8'h90) || (rx_dllp_type_i == 8'hA0));

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            fi2_reg <= 1'b0;
        end else begin
            fi2_reg <= (fi2_reg & ~clr_fi2) | fi2_hit;
        end
    end

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
`ifdef DLL_INITFC_TIMEOUT_EN
    logic [31:0] wd_reg;
    logic        timeout_reg;
    logic        wd_active;

    assign wd_active = (state_reg != ST_IDLE) && (state_reg != ST_DONE) && dl_init_i;
    assign wd_fire   = wd_active && (wd_reg == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            wd_reg      <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= wd_fire;
            if (!wd_active || wd_fire) begin
                wd_reg <= '0;
            end else begin
                wd_reg <= wd_reg + 32'd1;
            end
        end
    end

    assign timeout_o = timeout_reg;
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State machine
    // -----------------------------------------------------------------------
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= IDX_P;
            wait_reg  <= '0;
            sent_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            wait_reg  <= wait_next;
            sent_reg  <= sent_next;
        end
    end

    assign in_fi1   = (state_reg == ST_FI1_SEND) || (state_reg == ST_FI1_WAIT);
    assign phase_ok = in_fi1 ? (&fi1_reg) : fi2_reg;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        wait_next  = wait_reg;
        sent_next  = sent_reg;
        clr_fi1    = 1'b0;
        clr_fi2    = 1'b0;
        tx_valid   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (dl_init_i) begin
                    state_next = ST_FI1_SEND;
                    idx_next   = IDX_P;
                    wait_next  = '0;
                    sent_next  = 1'b0;
                    clr_fi1    = 1'b1;
                    clr_fi2    = 1'b1;
                end
            end

            ST_FI1_SEND, ST_FI2_SEND: begin
                tx_valid = 1'b1;
                if (tx_if.tx_req_ready) begin
                    if (idx_reg == IDX_CPL) begin
                        // Triplet boundary: the only place besides WAIT where
                        // the phase may advance. This Cpl handshake itself
                        // satisfies the "sent at least once" requirement.
                        if (phase_ok) begin
                            state_next = in_fi1 ? ST_FI2_SEND : ST_DONE;
                            idx_next   = IDX_P;
                            wait_next  = '0;
                            sent_next  = 1'b0;
                            clr_fi2    = in_fi1;
                        end else begin
                            state_next = in_fi1 ? ST_FI1_WAIT : ST_FI2_WAIT;
                            idx_next   = IDX_P;
                            wait_next  = WAIT_LOAD;
                            sent_next  = 1'b1;
                        end
                    end else begin
                        idx_next = idx_reg + 2'd1;
                    end
                end
            end

            ST_FI1_WAIT, ST_FI2_WAIT: begin
                if (phase_ok && sent_reg) begin
                    state_next = in_fi1 ? ST_FI2_SEND : ST_DONE;
                    idx_next   = IDX_P;
                    wait_next  = '0;
                    sent_next  = 1'b0;
                    clr_fi2    = in_fi1;
                end else if (wait_reg == '0) begin
                    state_next = in_fi1 ? ST_FI1_SEND : ST_FI2_SEND;
                    idx_next   = IDX_P;
                end else begin
                    wait_next = wait_reg - 1'b1;
                end
            end

            ST_DONE: begin
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Watchdog restart: back to the first triplet with a clean slate.
        if (wd_fire) begin
            state_next = ST_FI1_SEND;
            idx_next   = IDX_P;
            wait_next  = '0;
            sent_next  = 1'b0;
            clr_fi1    = 1'b1;
            clr_fi2    = 1'b1;
        end

        // Abort has the final word, even in the middle of a handshake.
        if (!dl_init_i) begin
            state_next = ST_IDLE;
            idx_next   = IDX_P;
            wait_next  = '0;
            sent_next  = 1'b0;
            clr_fi1    = 1'b1;
            clr_fi2    = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Request fields, decoded from phase and triplet index. They depend only
    // on registered state, so they hold steady while valid waits for ready.
    // -----------------------------------------------------------------------
    always_comb begin
        tx_if.tx_dllp_type = 8'h00;
        tx_if.tx_hdr_fc    = 8'h00;
        tx_if.tx_data_fc   = 12'h000;
        if (tx_valid) begin
            tx_if.tx_dllp_type = {(in_fi1 ? 2'b01 : 2'b11), idx_reg, 4'h0};
            case (idx_reg)
                2'd0: begin
                    tx_if.tx_hdr_fc  = PH_CREDIT;
                    tx_if.tx_data_fc = PD_CREDIT;
                end
                2'd1: begin
                    tx_if.tx_hdr_fc  = NPH_CREDIT;
                    tx_if.tx_data_fc = NPD_CREDIT;
                end
                default: begin
                    tx_if.tx_hdr_fc  = CPLH_CREDIT;
                    tx_if.tx_data_fc = CPLD_CREDIT;
                end
            endcase
        end
    end

    assign tx_if.tx_req_valid = tx_valid;
    assign fc_state_o         = state_reg;
    assign init1_end_o        = (state_reg == ST_FI2_SEND) || (state_reg == ST_FI2_WAIT) ||
                                (state_reg == ST_DONE);
    assign init2_end_o        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_dll_initfc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dll_initfc_ctrl
// Directed stimulus for dll_initfc_ctrl. Expected transmit requests
// {type, hdr, data} are queued by the stimulus thread; a monitor pops and
// compares one entry per accepted handshake. State/flag checks are made
// inline, #1 after the active clock edge.
// ---------------------------------------------------------------------------
module tb_dll_initfc_ctrl;

    logic        sclk = 1'b0;
    logic        srst = 1'b1;
    logic        dl_init_i = 1'b0;
    logic        rx_dllp_valid_i = 1'b0;
    logic [7:0]  rx_dllp_type_i = 8'h00;
    logic        init1_end_o;
    logic        init2_end_o;
    logic [2:0]  fc_state_o;
    logic        timeout_o;

    dll_initfc_ctrl_if tx_if ();

    always #5 sclk = ~sclk;

`ifdef DLL_INITFC_TIMEOUT_EN
    dll_initfc_ctrl #(.TIMEOUT_CYCLES(4096)) dut (
`else
    dll_initfc_ctrl dut (
`endif
        .sclk            (sclk),
        .srst            (srst),
        .dl_init_i       (dl_init_i),
        .rx_dllp_valid_i (rx_dllp_valid_i),
        .rx_dllp_type_i  (rx_dllp_type_i),
        .tx_if           (tx_if),
        .init1_end_o     (init1_end_o),
        .init2_end_o     (init2_end_o),
        .fc_state_o      (fc_state_o),
        .timeout_o       (timeout_o)
    );

    int n_total = 0;
    int n_pass  = 0;
    int hs_cnt  = 0;
    int cyc     = 0;
    int hs_cyc[$];
    logic [27:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
            $display("check %s: 0x%0h ok", name, act);
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic push3(input logic [1:0] phase_hi);
        exp_q.push_back({phase_hi, 2'd0, 4'h0, 8'd32, 12'd256});
        exp_q.push_back({phase_hi, 2'd1, 4'h0, 8'd32, 12'd64});
        exp_q.push_back({phase_hi, 2'd2, 4'h0, 8'd0,  12'd0});
    endtask

    task automatic wait_hs(input int target, input int budget, input string name);
        int n = 0;
        while (hs_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (hs_cnt < target) begin
            check(name, 32'(hs_cnt), 32'(target));
        end
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next
    // rising edge.
    always @(negedge sclk) begin
        cyc++;
        if (!srst && tx_if.tx_req_valid && tx_if.tx_req_ready) begin
            logic [27:0] act;
            act = {tx_if.tx_dllp_type, tx_if.tx_hdr_fc, tx_if.tx_data_fc};
            hs_cnt++;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_tx: got type 0x%0h hdr %0d data %0d, expected no request",
                         act[27:20], act[19:12], act[11:0]);
            end else begin
                logic [27:0] exp;
                exp = exp_q.pop_front();
                $display("tx type 0x%0h hdr %0d data %0d (exp 0x%0h/%0d/%0d)",
                         act[27:20], act[19:12], act[11:0], exp[27:20], exp[19:12], exp[11:0]);
                check("tx_dllp", 32'(act), 32'(exp));
            end
        end
    end

    initial begin
        int base;
        tx_if.tx_req_ready = 1'b1;

        // ---- Reset state ----
        #2;
        check("rst_state", 32'(fc_state_o), 32'd0);
        check("rst_valid", 32'(tx_if.tx_req_valid), 32'd0);
        check("rst_init_end", 32'({init1_end_o, init2_end_o, timeout_o}), 32'd0);
        tick();
        srst = 1'b0;
        tick();

        // ---- 1: no rx, triplets repeat with a 1024-cycle gap ----
        dl_init_i = 1'b1;
        push3(2'b01);
        push3(2'b01);
        base = hs_cnt;
        wait_hs(base + 3, 20, "t1_first_triplet");
        repeat (500) tick();
        check("t1_wait_state", 32'(fc_state_o), 32'd2);
        check("t1_wait_valid_init1", 32'({tx_if.tx_req_valid, init1_end_o, timeout_o}), 32'd0);
        wait_hs(base + 6, 1200, "t1_second_triplet");
        check("t1_back_to_back", 32'(hs_cyc[base + 2] - hs_cyc[base]), 32'd2);
        check("t1_resend_gap", 32'(hs_cyc[base + 3] - hs_cyc[base + 2]), 32'd1025);
        check("t1_init1_end", 32'(init1_end_o), 32'd0);

        // ---- Asynchronous reset mid-operation ----
        srst = 1'b1;
        #1;
        check("async_rst_state", 32'(fc_state_o), 32'd0);
        dl_init_i = 1'b0;
        tick();
        srst = 1'b0;
        tick();

        // ---- 2/3: rx InitFC1 during the first triplet, UpdateFC mid FI2 ----
        base = hs_cnt;
        push3(2'b01);
        push3(2'b11);
        dl_init_i = 1'b1;
        rx_dllp_valid_i = 1'b1;
        rx_dllp_type_i = 8'h40;          // arrives on the IDLE->FI1 entry edge
        tick();
        rx_dllp_type_i = 8'h50;
        tick();
        rx_dllp_type_i = 8'h60;
        tick();
        rx_dllp_valid_i = 1'b0;
        tick();                          // Cpl handshake edge
        check("t2_fi2_state", 32'(fc_state_o), 32'd3);
        check("t2_init_ends", 32'({init1_end_o, init2_end_o}), 32'b10);
        rx_dllp_valid_i = 1'b1;
        rx_dllp_type_i = 8'h80;
        tick();                          // 0xC0 accepted, fi2 set
        rx_dllp_valid_i = 1'b0;
        tick();                          // 0xD0
        check("t3_not_done_mid_triplet", 32'(fc_state_o), 32'd3);
        tick();                          // 0xE0 -> DONE
        check("t3_done_state", 32'(fc_state_o), 32'd5);
        check("t3_init_ends", 32'({init1_end_o, init2_end_o}), 32'b11);
        repeat (10) tick();
        check("t3_done_no_valid", 32'(tx_if.tx_req_valid), 32'd0);
        check("t3_hs_count", 32'(hs_cnt - base), 32'd6);

        // ---- 4: ready held low, fields stable ----
        dl_init_i = 1'b0;
        tx_if.tx_req_ready = 1'b0;
        tick();
        check("t4_idle", 32'(fc_state_o), 32'd0);
        dl_init_i = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_fields",
                  32'({tx_if.tx_req_valid, tx_if.tx_dllp_type, tx_if.tx_hdr_fc, tx_if.tx_data_fc}),
                  32'({1'b1, 8'h40, 8'd32, 12'd256}));
            tick();
        end
        base = hs_cnt;
        check("t4_no_hs_while_stalled", 32'(hs_cnt), 32'(base));
        push3(2'b01);
        tx_if.tx_req_ready = 1'b1;
        wait_hs(base + 3, 20, "t4_triplet");
        check("t4_wait_state", 32'(fc_state_o), 32'd2);

        // ---- 5: InitFC1 during WAIT, then abort while FI2_SEND stalls ----
        tx_if.tx_req_ready = 1'b0;
        rx_dllp_valid_i = 1'b1;
        rx_dllp_type_i = 8'h40;
        tick();
        rx_dllp_type_i = 8'h50;
        tick();
        rx_dllp_type_i = 8'h60;
        tick();
        rx_dllp_valid_i = 1'b0;
        tick();
        tick();
        check("t5_fi2_from_wait", 32'(fc_state_o), 32'd3);
        check("t5_fi2_fields",
              32'({tx_if.tx_req_valid, tx_if.tx_dllp_type, tx_if.tx_hdr_fc, tx_if.tx_data_fc}),
              32'({1'b1, 8'hC0, 8'd32, 12'd256}));
        dl_init_i = 1'b0;
        tick();
        check("t5_abort", 32'({fc_state_o, tx_if.tx_req_valid, init1_end_o}), 32'd0);
        base = hs_cnt;
        push3(2'b01);
        dl_init_i = 1'b1;
        tx_if.tx_req_ready = 1'b1;
        wait_hs(base + 3, 20, "t5_restart_triplet");
        check("t5_restart_wait", 32'(fc_state_o), 32'd2);

`ifdef DLL_INITFC_TIMEOUT_EN
        // ---- 6: watchdog ----
        begin
            int n = 0;
            srst = 1'b1;
            dl_init_i = 1'b0;
            tx_if.tx_req_ready = 1'b0;
            tick();
            srst = 1'b0;
            dl_init_i = 1'b1;
            tick();
            while (!timeout_o && n < 5000) begin
                tick();
                n++;
            end
            check("t6_timeout_cycle", 32'(n), 32'd4096);
            check("t6_reissue", 32'({fc_state_o, tx_if.tx_req_valid, tx_if.tx_dllp_type}),
                  32'({3'd1, 1'b1, 8'h40}));
            tick();
            check("t6_pulse_width", 32'(timeout_o), 32'd0);
        end
`endif

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
